matrix_transpose: RTL and testbench

Streaming 3x3 transpose stage directly upstream of `matrix_multiplication`. It accepts the nine Q-matrix elements in row-major order, one per handshake, buffers the full matrix, and replays the elements in column-major (transposed) order. The replayed elements drive the multiplier's `transpose_out` operand, paired with `valid_mul`. Data is Q4.12 and passes through bit-exact; no arithmetic is performed.

---
 rtl/matrix_transpose.sv | 105 ++++++++++
 tb/tb_matrix_transpose.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/matrix_transpose.sv
// Streaming square-matrix transpose: buffers one row-major matrix, then replays it
// column-major with a valid/ready handshake on both sides. Not double-buffered.
//
// state   | meaning
// S_LOAD  | accepting row-major input, output idle
// S_DRAIN | replaying buffer column-major, input stalled
module matrix_transpose #(
    parameter int WORDLEN            = 16,
    parameter int MATRIX_ELEMENT_NUM = 9,
    parameter int MATRIX_DIM         = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WORDLEN-1:0] q_in,
    input  logic               valid_in,
    output logic               in_ready,
    output logic [WORDLEN-1:0] transpose_out,
    output logic               valid_transpose,
    input  logic               out_ready,
    output logic               done_transpose
);
    localparam int CW = $clog2(MATRIX_DIM);
    localparam int AW = $clog2(MATRIX_ELEMENT_NUM);
    localparam logic [CW-1:0] LAST = CW'(MATRIX_DIM - 1);

    typedef enum logic {S_LOAD, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_wr_row, r_wr_col, r_rd_row, r_rd_col;
    logic [CW-1:0]      w_rd_row_nxt, w_rd_col_nxt;
    logic [WORDLEN-1:0] r_buf [MATRIX_ELEMENT_NUM];
    logic [WORDLEN-1:0] r_out;
    logic               r_done;
    logic [AW-1:0]      w_wr_addr, w_rd_addr_nxt;
    logic               w_in_acc, w_out_acc, w_last_in, w_last_out;

    assign in_ready        = (r_state == S_LOAD);
    assign valid_transpose = (r_state == S_DRAIN);
    assign transpose_out   = r_out;
    assign done_transpose  = r_done;

    assign w_in_acc   = valid_in && in_ready;
    assign w_out_acc  = out_ready && valid_transpose;
    assign w_last_in  = w_in_acc && (r_wr_row == LAST) && (r_wr_col == LAST);
    assign w_last_out = w_out_acc && (r_rd_row == LAST) && (r_rd_col == LAST);

    // Column-major walk: row is the fast index on the read side.
    assign w_rd_row_nxt  = (r_rd_row == LAST) ? '0 : r_rd_row + CW'(1);
    assign w_rd_col_nxt  = (r_rd_row == LAST) ? r_rd_col + CW'(1) : r_rd_col;
    assign w_wr_addr     = AW'(r_wr_row) * AW'(MATRIX_DIM) + AW'(r_wr_col);
    assign w_rd_addr_nxt = AW'(w_rd_row_nxt) * AW'(MATRIX_DIM) + AW'(w_rd_col_nxt);

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_LOAD;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (w_last_in)  w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_out) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Buffer is left uninitialised on reset; counters and state alone define validity.
    always_ff @(posedge CLK) begin
        if (w_in_acc) r_buf[w_wr_addr] <= q_in;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_row <= '0;
            r_wr_col <= '0;
            r_rd_row <= '0;
            r_rd_col <= '0;
            r_out    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last_out;
            if (w_in_acc) begin
                if (r_wr_col == LAST) begin
                    r_wr_col <= '0;
                    r_wr_row <= (r_wr_row == LAST) ? '0 : r_wr_row + CW'(1);
                end else begin
                    r_wr_col <= r_wr_col + CW'(1);
                end
            end
            // Element (0,0) was written on the first accept, so it can be presented now.
            if (w_last_in) r_out <= r_buf[0];
            if (w_out_acc) begin
                if (w_last_out) begin
                    r_rd_row <= '0;
                    r_rd_col <= '0;
                end else begin
                    r_rd_row <= w_rd_row_nxt;
                    r_rd_col <= w_rd_col_nxt;
                    r_out    <= r_buf[w_rd_addr_nxt];
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_transpose.sv
// Directed bench for matrix_transpose: hand-computed column-major sequences
// under gaps, backpressure, protocol violation, mid-drain reset and back-to-back load.
module tb_matrix_transpose;
    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] q_in;
    logic        valid_in;
    logic        in_ready;
    logic [15:0] transpose_out;
    logic        valid_transpose;
    logic        out_ready;
    logic        done_transpose;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0;

    logic [15:0] vin  [9];
    logic [15:0] vexp [9];

    matrix_transpose #(.WORDLEN(16), .MATRIX_ELEMENT_NUM(9), .MATRIX_DIM(3)) dut (
        .CLK(CLK), .RST(RST), .q_in(q_in), .valid_in(valid_in), .in_ready(in_ready),
        .transpose_out(transpose_out), .valid_transpose(valid_transpose),
        .out_ready(out_ready), .done_transpose(done_transpose)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Loads vin; gap inserts one idle cycle between accepts.
    task automatic load_matrix(input bit gap, input bit keep_valid);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("in_ready_load%0d", i), 32'(in_ready), 32'd1);
            valid_in = 1'b1;
            q_in     = vin[i];
            tick();
            if (gap && i < 8) begin
                valid_in = 1'b0;
                q_in     = 16'hAAAA;
                tick();
            end
        end
        if (!keep_valid) valid_in = 1'b0;
    endtask

    // Drains against vexp, optional stall of stall_len cycles at stall_idx,
    // optionally driving 0xFFFF on valid_in throughout.
    task automatic drain_check(input int stall_idx, input int stall_len, input bit junk);
        if (junk) begin
            valid_in = 1'b1;
            q_in     = 16'hFFFF;
        end
        for (int k = 0; k < 9; k++) begin
            if (k == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check_eq($sformatf("stall_data%0d", s), 32'(transpose_out), 32'(vexp[k]));
                    check_eq($sformatf("stall_valid%0d", s), 32'(valid_transpose), 32'd1);
                end
                out_ready = 1'b1;
            end
            check_eq($sformatf("out_valid%0d", k), 32'(valid_transpose), 32'd1);
            check_eq($sformatf("out_data%0d", k), 32'(transpose_out), 32'(vexp[k]));
            check_eq($sformatf("in_ready_drain%0d", k), 32'(in_ready), 32'd0);
            tick();
        end
        check_eq("done_pulse", 32'(done_transpose), 32'd1);
        check_eq("done_in_ready", 32'(in_ready), 32'd1);
        check_eq("done_valid", 32'(valid_transpose), 32'd0);
        check_eq("done_hold_out", 32'(transpose_out), 32'(vexp[8]));
    endtask

    task automatic set_seq(input logic [15:0] base);
        for (int i = 0; i < 9; i++) vin[i] = base + 16'(i);
        for (int k = 0; k < 9; k++) vexp[k] = base + 16'((k % 3) * 3 + k / 3);
    endtask

    initial begin
        RST = 1'b1; valid_in = 1'b0; q_in = 16'h0; out_ready = 1'b1;
        tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_valid", 32'(valid_transpose), 32'd0);
        check_eq("rst_done", 32'(done_transpose), 32'd0);
        check_eq("rst_out", 32'(transpose_out), 32'd0);
        tick();
        RST = 1'b0;

        // Basic transpose
        vin  = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8, 16'h9};
        vexp = '{16'h1, 16'h4, 16'h7, 16'h2, 16'h5, 16'h8, 16'h3, 16'h6, 16'h9};
        load_matrix(1'b0, 1'b0);
        drain_check(-1, 0, 1'b0);
        tick();
        check_eq("done_once", 32'(done_transpose), 32'd0);

        // Sparse input with signed data
        vin  = '{16'h1, 16'h2, 16'hF4CD, 16'hFEB8, 16'h5, 16'h6, 16'h7, 16'h8, 16'h9};
        vexp = '{16'h1, 16'hFEB8, 16'h7, 16'h2, 16'h5, 16'h8, 16'hF4CD, 16'h6, 16'h9};
        load_matrix(1'b1, 1'b0);
        drain_check(-1, 0, 1'b0);
        tick();

        // Backpressure at output index 4
        set_seq(16'h1);
        load_matrix(1'b0, 1'b0);
        drain_check(4, 3, 1'b0);
        tick();

        // Protocol violation: junk on valid_in during drain, then a clean reload
        set_seq(16'h1);
        load_matrix(1'b0, 1'b0);
        drain_check(-1, 0, 1'b1);
        valid_in = 1'b0;
        tick();
        set_seq(16'h21);
        load_matrix(1'b0, 1'b0);
        drain_check(-1, 0, 1'b0);
        tick();

        // Reset after output index 3
        set_seq(16'h1);
        load_matrix(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("pre_rst_out%0d", k), 32'(transpose_out), 32'(vexp[k]));
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_eq("mid_rst_valid", 32'(valid_transpose), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_out", 32'(transpose_out), 32'd0);
        set_seq(16'h10);
        load_matrix(1'b0, 1'b0);
        drain_check(-1, 0, 1'b0);

        // Back-to-back with valid_in held high; second load starts in the done cycle
        tick();
        t0 = cyc;
        set_seq(16'h31);
        load_matrix(1'b0, 1'b1);
        drain_check(-1, 0, 1'b1);
        set_seq(16'h41);
        load_matrix(1'b0, 1'b1);
        drain_check(-1, 0, 1'b1);
        valid_in = 1'b0;
        check_eq("b2b_cycles", 32'(cyc - t0), 32'd36);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
